// File: rtl/pipe_add_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : pipe_add_if                                            |
// | Description : Operand/result handshake bundle for pipe_add.          |
// |               Signal sub exists only when PIPE_ADD_SUB_EN is set.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface pipe_add_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPE_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side (testbench or upstream logic)
  modport master (
`ifdef PIPE_ADD_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side
  modport slave (
`ifdef PIPE_ADD_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/pipe_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_add                                               |
// | Description : Segmented carry-pipelined adder. Each stage adds one   |
// |               SEG-bit segment and passes its carry to the next stage.|
// |               Valid/ready handshake with per-stage bubble collapse.  |
// |               Define PIPE_ADD_SUB_EN to add the sub (a - b) input.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module pipe_add #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  pipe_add_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;

  if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_cfg
    $error("pipe_add: WIDTH must be a nonzero multiple of SEG");
  end

  logic [STAGES-1:0] valid_d, valid_q;
  logic [STAGES-1:0] adv;   // stage k hands its contents on this cycle
  logic [STAGES-1:0] load;  // stage k captures new contents this cycle
  logic [STAGES:0]   take;  // position k can accept data this cycle

  // Back-pressure chain, walked from the output toward the input.
  always_comb begin
    take         = '0;
    adv          = '0;
    take[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]  = valid_q[k] && take[k+1];
      take[k] = !valid_q[k] || adv[k];
    end
    load    = adv << 1;
    load[0] = bus.in_valid && take[0];
    valid_d = (valid_q & ~adv) | load;
  end

  // Valid bits; reset drops every in-flight operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // in_ready looks only at state and out_ready, never at in_valid.
  assign bus.in_ready  = take[0];
  assign bus.out_valid = valid_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * SEG;      // first bit of the segment added here
    localparam int DONE = LO + SEG;     // result bits complete after this stage
    localparam int REM  = WIDTH - DONE; // operand bits still waiting upstream

    logic [WIDTH-LO-1:0] a_up;     // operand bits from this segment upward
    logic [WIDTH-LO-1:0] b_up;
    logic                sub_up;
    logic                cin_up;
    logic [DONE-1:0]     sum_new;
    logic [DONE-1:0]     sum_d, sum_q;
    logic [SEG-1:0]      b_eff;
    logic [SEG:0]        seg_res;
    logic                carry_d, carry_q;

    if (k == 0) begin : g_src_in
      assign a_up    = bus.a;
      assign b_up    = bus.b;
`ifdef PIPE_ADD_SUB_EN
      // Subtraction is a + ~b + 1, so the external carry is overridden.
      assign sub_up  = bus.sub;
      assign cin_up  = bus.sub | bus.cin;
`else
      assign sub_up  = 1'b0;
      assign cin_up  = bus.cin;
`endif
      assign sum_new = seg_res[SEG-1:0];
    end else begin : g_src_prev
      assign a_up    = g_stage[k-1].g_fwd.a_q;
      assign b_up    = g_stage[k-1].g_fwd.b_q;
      assign sub_up  = g_stage[k-1].g_fwd.sub_q;
      assign cin_up  = g_stage[k-1].carry_q;
      assign sum_new = {seg_res[SEG-1:0], g_stage[k-1].sum_q};
    end

    // Segment adder; b is inverted here so sub travels through unmodified.
    always_comb begin
      b_eff   = b_up[SEG-1:0] ^ {SEG{sub_up}};
      seg_res = {1'b0, a_up[SEG-1:0]} + {1'b0, b_eff} + {{SEG{1'b0}}, cin_up};
    end

    // Result bits and carry are captured only when the stage loads.
    always_comb begin
      sum_d   = load[k] ? sum_new : sum_q;
      carry_d = load[k] ? seg_res[SEG] : carry_q;
    end

    // Result and carry registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end

    if (REM > 0) begin : g_fwd
      logic [REM-1:0] a_d, a_q;
      logic [REM-1:0] b_d, b_q;
      logic           sub_d, sub_q;

      // Untouched upper operand bits ride along with the operation.
      always_comb begin
        a_d   = load[k] ? a_up[WIDTH-LO-1:SEG] : a_q;
        b_d   = load[k] ? b_up[WIDTH-LO-1:SEG] : b_q;
        sub_d = load[k] ? sub_up : sub_q;
      end

      // Forwarded operand registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          sub_q <= sub_d;
        end
      end
    end else begin : g_last
      logic ovf_d, ovf_q;

      // MSB sum bit = a ^ b ^ carry_in, so carry-in to the MSB is recoverable.
      always_comb begin
        ovf_d = load[k] ? (seg_res[SEG] ^ seg_res[SEG-1] ^ a_up[SEG-1] ^ b_eff[SEG-1])
                        : ovf_q;
      end

      // Overflow flag register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
      end

      assign bus.sum  = sum_q;
      assign bus.cout = carry_q;
      assign bus.ovf  = ovf_q;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pipe_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pipe_add                                            |
// | Description : Directed self-checking bench for pipe_add (32/8).      |
// |               Subtraction vectors run when PIPE_ADD_SUB_EN is set.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pipe_add;
  localparam int WIDTH  = 32;
  localparam int SEG    = 8;
  localparam int STAGES = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipe_add_if #(.WIDTH(WIDTH)) bus ();

  pipe_add #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One isolated operation: checks acceptance, latency and the result.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [31:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf);
    int lat;
    @(negedge clk);
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
`ifdef PIPE_ADD_SUB_EN
    bus.sub       = sub;
`else
    if (sub) $display("note: sub vector %s issued without subtract support", tag);
`endif
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(STAGES));
    check({tag, ".sum"},  64'(bus.sum),  64'(exp_sum));
    check({tag, ".cout"}, 64'(bus.cout), 64'(exp_cout));
    check({tag, ".ovf"},  64'(bus.ovf),  64'(exp_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, first_c, last_c, idle_valid;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
`ifdef PIPE_ADD_SUB_EN
    bus.sub       = 1'b0;
`endif
    bus.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset.out_valid", 64'(bus.out_valid), 64'd0);
    check("reset.sum",       64'(bus.sum),       64'd0);
    check("reset.cout",      64'(bus.cout),      64'd0);
    check("reset.ovf",       64'(bus.ovf),       64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset.in_ready", 64'(bus.in_ready), 64'd1);

    // Directed addition vectors
    run_one("carry_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_one("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("neg_ovf",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run_one("mixed_cin", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0);
    run_one("cin_only",  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
    run_one("seg_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);

`ifdef PIPE_ADD_SUB_EN
    run_one("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_plain",  32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
`endif

    // Back-to-back stream with a six-cycle output stall
    sent    = 0;
    got     = 0;
    first_c = -1;
    last_c  = -1;
    for (int c = 1; c <= 40 && got < 8; c++) begin
      @(negedge clk);
      bus.out_ready = (c > 6);
      bus.in_valid  = (sent < 8);
      bus.a         = 32'(sent + 1);
      bus.b         = 32'(sent + 1);
      bus.cin       = 1'b0;
      #1;
      if (c == 5) check("stall.in_ready", 64'(bus.in_ready), 64'd0);
      if (c == 5 || c == 6) begin
        check($sformatf("stall.valid_c%0d", c), 64'(bus.out_valid), 64'd1);
        check($sformatf("stall.hold_c%0d", c),  64'(bus.sum),       64'd2);
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("stream.out%0d", got), 64'(bus.sum), 64'(2 * (got + 1)));
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (c == 6) check("stall.accepts", 64'(sent), 64'd4);
      @(posedge clk);
    end
    check("stream.count", 64'(got), 64'd8);
    check("stream.no_gaps", 64'(last_c - first_c), 64'd7);
    @(negedge clk);
    bus.in_valid = 1'b0;

    // Reset with three operations in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 32'(100 + i);
      bus.b        = 32'd1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst.pre_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.async_valid", 64'(bus.out_valid), 64'd0);
    check("rst.async_sum",   64'(bus.sum),       64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    idle_valid    = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) idle_valid++;
    end
    check("rst.no_stale", 64'(idle_valid), 64'd0);
    run_one("rst.fresh", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
